// File: rtl/sample_decimator_if.sv
// Output stream of the decimator: valid/ready handshake carrying one signed sample.
// The master drives valid and data; the slave drives ready.
interface sample_decimator_if #(
   parameter int OUT_W = 16
);
   logic                    m_valid;
   logic                    m_ready;
   logic signed [OUT_W-1:0] m_data;

   modport master (output m_valid, output m_data, input m_ready);
   modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/sample_decimator.sv
// Decimates a phasor stream by decim, shifts and saturates, and queues results in a FIFO.
// Push lands on the tick edge, valid the next cycle; a push into a full FIFO without a pop is dropped and flags overflow.
module sample_decimator #(
   parameter int IN_W  = 20,
   parameter int OUT_W = 16,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   input  logic signed [IN_W-1:0] sample_in,
   input  logic [7:0]             decim,
   input  logic [2:0]             shift,
   input  logic                   clr_ovf,
   sample_decimator_if.master     m,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
   localparam logic signed [IN_W-1:0] SAT_MAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IN_W-1:0] SAT_MIN = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic [7:0]              r_cnt;
   logic [AW-1:0]           r_wptr;
   logic [AW-1:0]           r_rptr;
   logic [AW:0]             r_level;
   logic                    r_ovf;
   logic signed [OUT_W-1:0] r_mem [DEPTH];

   logic [7:0]              w_ratio_m1;
   logic                    w_tick;
   logic signed [IN_W-1:0]  w_shifted;
   logic signed [OUT_W-1:0] w_sat;
   logic                    w_valid;
   logic                    w_full;
   logic                    w_pop;
   logic                    w_push;
   logic                    w_drop;

   // >= rather than == so a ratio lowered mid-window ends the window immediately
   assign w_ratio_m1 = (decim == 8'd0) ? 8'd0 : decim - 8'd1;
   assign w_tick     = en && (r_cnt >= w_ratio_m1);
   assign w_shifted  = sample_in >>> shift;

   always_comb begin
      w_sat = w_shifted[OUT_W-1:0];
      if (w_shifted > SAT_MAX)
         w_sat = SAT_MAX[OUT_W-1:0];
      else if (w_shifted < SAT_MIN)
         w_sat = SAT_MIN[OUT_W-1:0];
   end

   assign w_valid = (r_level != '0);
   assign w_full  = (r_level == FULL_LVL);
   assign w_pop   = w_valid && m.m_ready;
   // A pop frees the slot in the same edge, so full plus pop still accepts the push
   assign w_push  = w_tick && (!w_full || w_pop);
   assign w_drop  = w_tick && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= 8'd0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (en)
            r_cnt <= w_tick ? 8'd0 : r_cnt + 8'd1;
         if (w_push)
            r_wptr <= r_wptr + AW'(1);
         if (w_pop)
            r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
         if (w_drop)
            r_ovf <= 1'b1;
         else if (clr_ovf)
            r_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_push)
         r_mem[r_wptr] <= w_sat;
   end

   assign m.m_valid = w_valid;
   assign m.m_data  = w_valid ? r_mem[r_rptr] : '0;
   assign level     = r_level;
   assign overflow  = r_ovf;
endmodule

// File: tb/tb_sample_decimator.sv
// Directed bench for sample_decimator: decimation timing, shift/saturation, FIFO full/overflow, resets.
module tb_sample_decimator;
   logic               clk = 1'b0;
   logic               reset;
   logic               en;
   logic signed [19:0] sample_in;
   logic [7:0]         decim;
   logic [2:0]         shift;
   logic               clr_ovf;
   logic [3:0]         level;
   logic               overflow;

   int n_tests = 0;
   int n_fail  = 0;

   sample_decimator_if #(.OUT_W(16)) m_if ();

   sample_decimator #(.IN_W(20), .OUT_W(16), .DEPTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .sample_in (sample_in),
      .decim     (decim),
      .shift     (shift),
      .clr_ovf   (clr_ovf),
      .m         (m_if),
      .level     (level),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; en = 1'b0; m_if.m_ready = 1'b0; clr_ovf = 1'b0;
      decim = 8'd1; shift = 3'd0; sample_in = '0;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; en = 1'b1; m_if.m_ready = 1'b0; clr_ovf = 1'b0;
      decim = 8'd1; shift = 3'd0; sample_in = 20'sd123;
      step();
      step();
      n_tests++;
      if (m_if.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", m_if.m_valid); end
      n_tests++;
      if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
      n_tests++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
      n_tests++;
      if (m_if.m_data !== 16'd0) begin n_fail++; $display("FAIL reset_data: got %0d want 0", m_if.m_data); end
      reset = 1'b0;
   endtask

   task automatic test_decimation();
      logic want_v;
      do_reset();
      decim = 8'd4; en = 1'b1; m_if.m_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         sample_in = 20'(k);
         step();
         want_v = ((k % 4) == 3);
         n_tests++;
         if (m_if.m_valid !== want_v) begin n_fail++; $display("FAIL decim4_valid[%0d]: got %b want %b", k, m_if.m_valid, want_v); end
         if (want_v) begin
            n_tests++;
            if (m_if.m_data !== 16'(k)) begin n_fail++; $display("FAIL decim4_data[%0d]: got %0d want %0d", k, $signed(m_if.m_data), k); end
         end
      end
   endtask

   task automatic test_shift_sat();
      int v_shift [8] = '{0, 0, 2, 7, 3, 0, 0, 0};
      int v_in    [8] = '{40000, -40000, -40000, -1, 1000, 32767, -32768, 32768};
      int v_exp   [8] = '{32767, -32768, -10000, -1, 125, 32767, -32768, 32767};
      logic signed [15:0] exp16;
      for (int i = 0; i < 8; i++) begin
         do_reset();
         decim = 8'd1; shift = 3'(v_shift[i]); sample_in = 20'(v_in[i]); en = 1'b1;
         step();
         en = 1'b0;
         exp16 = 16'(v_exp[i]);
         n_tests++;
         if (m_if.m_valid !== 1'b1 || m_if.m_data !== exp16) begin
            n_fail++;
            $display("FAIL sat[%0d]: got v=%b d=%0d want v=1 d=%0d", i, m_if.m_valid, $signed(m_if.m_data), exp16);
         end
      end
   endtask

   task automatic test_param_change();
      do_reset();
      decim = 8'd1; shift = 3'd0; sample_in = 20'sd64; en = 1'b1;
      step();
      shift = 3'd4;
      step();
      en = 1'b0; m_if.m_ready = 1'b1;
      n_tests++;
      if (m_if.m_data !== 16'sd64) begin n_fail++; $display("FAIL param_first: got %0d want 64", $signed(m_if.m_data)); end
      step();
      n_tests++;
      if (m_if.m_data !== 16'sd4) begin n_fail++; $display("FAIL param_second: got %0d want 4", $signed(m_if.m_data)); end
      step();
   endtask

   task automatic test_overflow();
      do_reset();
      decim = 8'd1; en = 1'b1;
      for (int k = 0; k < 12; k++) begin
         sample_in = 20'(100 + k);
         step();
      end
      n_tests++;
      if (level !== 4'd8) begin n_fail++; $display("FAIL ovf_level: got %0d want 8", level); end
      n_tests++;
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
      clr_ovf = 1'b1;
      step();
      n_tests++;
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_clr_and_drop: got %b want 1", overflow); end
      en = 1'b0;
      step();
      clr_ovf = 1'b0;
      n_tests++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b want 0", overflow); end
      m_if.m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (m_if.m_valid !== 1'b1 || m_if.m_data !== 16'(100 + i)) begin
            n_fail++;
            $display("FAIL ovf_order[%0d]: got v=%b d=%0d want v=1 d=%0d", i, m_if.m_valid, $signed(m_if.m_data), 100 + i);
         end
         step();
      end
      n_tests++;
      if (m_if.m_valid !== 1'b0 || level !== 4'd0) begin n_fail++; $display("FAIL ovf_drained: got v=%b lvl=%0d want v=0 lvl=0", m_if.m_valid, level); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      decim = 8'd1; en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         sample_in = 20'(k);
         step();
      end
      m_if.m_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         sample_in = 20'(8 + i);
         n_tests++;
         if (m_if.m_data !== 16'(i)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %0d want %0d", i, $signed(m_if.m_data), i); end
         step();
         n_tests++;
         if (level !== 4'd8 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_level[%0d]: got lvl=%0d ovf=%b want lvl=8 ovf=0", i, level, overflow);
         end
      end
      en = 1'b0;
   endtask

   task automatic test_mid_change();
      logic want_v;
      do_reset();
      decim = 8'd200; en = 1'b1; m_if.m_ready = 1'b1; sample_in = 20'sd7;
      for (int k = 0; k < 50; k++) step();
      n_tests++;
      if (level !== 4'd0) begin n_fail++; $display("FAIL mid_no_tick: got lvl=%0d want 0", level); end
      decim = 8'd3;
      step();
      n_tests++;
      if (m_if.m_valid !== 1'b1 || m_if.m_data !== 16'sd7) begin
         n_fail++;
         $display("FAIL mid_first_tick: got v=%b d=%0d want v=1 d=7", m_if.m_valid, $signed(m_if.m_data));
      end
      for (int k = 1; k < 10; k++) begin
         sample_in = 20'(7 + k);
         step();
         want_v = ((k % 3) == 0);
         n_tests++;
         if (m_if.m_valid !== want_v || (want_v && m_if.m_data !== 16'(7 + k))) begin
            n_fail++;
            $display("FAIL mid_period[%0d]: got v=%b d=%0d want v=%b d=%0d", k, m_if.m_valid, $signed(m_if.m_data), want_v, 7 + k);
         end
      end
      do_reset();
      decim = 8'd1; en = 1'b1;
      for (int k = 0; k < 5; k++) step();
      n_tests++;
      if (level !== 4'd5) begin n_fail++; $display("FAIL mid_fill5: got lvl=%0d want 5", level); end
      reset = 1'b1; m_if.m_ready = 1'b1;
      step();
      reset = 1'b0; en = 1'b0;
      n_tests++;
      if (m_if.m_valid !== 1'b0 || level !== 4'd0 || m_if.m_data !== 16'd0) begin
         n_fail++;
         $display("FAIL mid_reset: got v=%b lvl=%0d d=%0d want v=0 lvl=0 d=0", m_if.m_valid, level, $signed(m_if.m_data));
      end
   endtask

   task automatic test_decim_zero_drain();
      do_reset();
      decim = 8'd0; en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sample_in = 20'(50 + i);
         step();
         n_tests++;
         if (level !== 4'(i + 1)) begin n_fail++; $display("FAIL d0_level[%0d]: got %0d want %0d", i, level, i + 1); end
      end
      en = 1'b0; m_if.m_ready = 1'b1; sample_in = 20'sd99;
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (m_if.m_data !== 16'(50 + i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %0d want %0d", i, $signed(m_if.m_data), 50 + i); end
         step();
      end
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (m_if.m_valid !== 1'b0 || level !== 4'd0) begin
            n_fail++;
            $display("FAIL drain_idle[%0d]: got v=%b lvl=%0d want v=0 lvl=0", i, m_if.m_valid, level);
         end
         step();
      end
   endtask

   initial begin
      m_if.m_ready = 1'b0;
      test_reset();
      test_decimation();
      test_shift_sat();
      test_param_change();
      test_overflow();
      test_back_to_back();
      test_mid_change();
      test_decim_zero_drain();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
